// File: rtl/systolic_loader.sv
// rtl/systolic_loader.sv - fetches an N x N int8 tile row by row and streams it into the systolic arranger
module systolic_loader #(
  parameter int N      = 4,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [8*N-1:0]      mem_rdata,
  output logic                systolic_en,
  output logic                systolic_ctr,
  output logic [8*N*N-1:0]    systolic_in
);

  localparam int CW = $clog2(N) + 1;
  localparam int SW = $clog2(2 * N) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [CW-1:0]       req_cnt;
  logic [CW-1:0]       rsp_cnt;
  logic [SW-1:0]       str_cnt;
  logic [8*N*N-1:0]    tile_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    systolic_en  = 1'b0;
    systolic_ctr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = (req_cnt < CW'(N));
        if (mem_rvalid && rsp_cnt == CW'(N - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy        = 1'b1;
        systolic_en = 1'b1;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        busy         = 1'b1;
        systolic_ctr = 1'b1;
        if (str_cnt == SW'(2 * N - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address follows the request counter, so it holds naturally while mem_ready is low.
  assign mem_addr    = base_q + ADDR_W'(req_cnt);
  assign systolic_in = tile_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
      str_cnt <= '0;
      tile_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            req_cnt <= '0;
            rsp_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (mem_req && mem_ready) req_cnt <= req_cnt + 1'b1;
          if (mem_rvalid && rsp_cnt < CW'(N)) begin
            for (int r = 0; r < N; r++) begin
              if (rsp_cnt == CW'(r)) tile_q[r*8*N +: 8*N] <= mem_rdata;
            end
            rsp_cnt <= rsp_cnt + 1'b1;
          end
        end
        S_LOAD:   str_cnt <= '0;
        S_STREAM: str_cnt <= str_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/systolic_loader.md
Name: systolic_loader

Overview:
- Upstream feeder for the systolic arranger stage.
- On a start pulse it fetches an N x N int8 operand tile, one row per beat, from the unified buffer through a request/response port. It packs the tile into the 8*N*N-bit arranger input bus.
- It then loads the arranger with a one-cycle systolic_en and runs the skew sequence by holding systolic_ctr for exactly 2N cycles.
- Reports completion with a done pulse.

Parameters:
- N, 4, tile dimension (rows = columns = N); must match the arranger's N.
- ADDR_W, 8, unified-buffer row-address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to load and stream a tile; ignored unless idle.
- base_addr  input  ADDR_W  row address of tile row 0; sampled on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the stream completes.
- mem_req  output  1  row read request valid.
- mem_addr  output  ADDR_W  row address of the current request.
- mem_ready  input  1  request accepted when mem_req && mem_ready.
- mem_rvalid  input  1  read data valid; responses arrive in request order, latency >= 1.
- mem_rdata  input  8*N  one tile row; element (r,j) is at bits [8j+7:8j].
- systolic_en  output  1  arranger load strobe.
- systolic_ctr  output  1  arranger run enable.
- systolic_in  output  8*N*N  packed tile; element (r,j) is at bits [8(rN+j)+7 : 8(rN+j)].

Behaviour:
- Reset (async, active-high, immediate):
  - State goes to IDLE.
  - busy, done, mem_req, systolic_en, systolic_ctr = 0.
  - mem_addr = 0 and systolic_in = 0.
  - All counters = 0.
  - Reset mid-operation aborts the tile. Responses still in flight after reset deasserts are ignored because the state is IDLE.
- IDLE:
  - start=1 latches base_addr, clears req_cnt and rsp_cnt, and moves to FETCH.
  - start in any other state is ignored.
- FETCH, request side:
  - mem_req = (req_cnt < N).
  - mem_addr = base_addr + req_cnt, modulo 2^ADDR_W (wraps).
  - mem_req and mem_addr are held stable while mem_ready=0.
  - On each accepted request, req_cnt increments. Once req_cnt = N, mem_req drops in the same cycle as the update.
- FETCH, response side:
  - Each mem_rvalid writes mem_rdata into row rsp_cnt of systolic_in and increments rsp_cnt.
  - An accept and a response in the same cycle are both processed.
  - When the Nth response is captured, the next state is LOAD.
  - mem_rvalid beyond N responses, or outside FETCH, is ignored.
- LOAD: systolic_en=1 for exactly one cycle; next state STREAM.
- STREAM:
  - systolic_ctr=1 for exactly 2N consecutive cycles (the arranger's 2N-1 skew steps plus its wrap cycle).
  - Counted by a $clog2(2N)+1-bit counter.
  - Next state DONE.
- DONE: done=1 for one cycle, busy deasserts in the same cycle, next state IDLE.
- busy = 1 in FETCH, LOAD and STREAM; 0 in IDLE and DONE.
- systolic_in is registered. It changes only on response capture in FETCH and stays stable through LOAD, STREAM and until the next tile's first response.
- systolic_en and systolic_ctr are never high in the same cycle.
- Minimum latency, start to done, with mem_ready=1 and a response latency of 1: 1 (IDLE->FETCH) + N+1 (fetch) + 1 (LOAD) + 2N (STREAM) + 1 (DONE) cycles.

Test Plan:
- N=4, base_addr=0x10, mem_ready=1, latency 1, rows = {0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D} -> mem_addr sequence 0x10..0x13. systolic_in = 0x100F0E0D_0C0B0A09_08070605_04030201. One systolic_en, then 8 cycles of systolic_ctr, then done; end-to-end through the arranger, its first output column = {0,0,0,0x01}.
- mem_ready toggling 1,0,0,1,... with response latency 3 -> mem_req/mem_addr held during stalls. Exactly 4 accepts at addresses base..base+3. Tile packed identically to the first scenario.
- base_addr=0xFE -> addresses 0xFE, 0xFF, 0x00, 0x01 (wrap).
- start pulsed again during STREAM, plus a spurious mem_rvalid in STREAM -> both ignored; systolic_in unchanged; exactly one done.
- Assert reset while rsp_cnt=2, then deliver the remaining 2 responses after release -> all outputs return to 0 and stay IDLE. A new start fetches a fresh tile with correct packing.
- Back-to-back tiles: start pulsed the cycle after done -> accepted; second tile streams with its own data; systolic_ctr total = 16 cycles across both tiles.
